// File: rtl/mxv_stream_engine.sv
// rtl/mxv_stream_engine.sv - streaming NxN matrix-vector multiply engine with grouped MAC lanes
module mxv_stream_engine #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20,
  parameter int LANES  = 4,
  parameter int MAX_N  = 8,
  parameter int SAT    = 0,
  parameter int NW     = $clog2(MAX_N + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NW-1:0]     n_in,
  input  logic              n_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              err
);

  localparam int IW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD_M  = 3'd1;
  localparam logic [2:0] S_LOAD_V  = 3'd2;
  localparam logic [2:0] S_COMPUTE = 3'd3;
  localparam logic [2:0] S_DRAIN   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [NW-1:0]     n_q, n_d;
  logic [NW-1:0]     row_q, row_d;     // load row counter
  logic [NW-1:0]     col_q, col_d;     // load column / vector index
  logic [NW-1:0]     cyc_q, cyc_d;     // COMPUTE cycle, doubles as k for the store read
  logic [NW-1:0]     base_q, base_d;   // row index of lane 0 in the current group
  logic [LW-1:0]     lane_q, lane_d;   // lane being drained
  logic              err_q, err_d;
  logic [ACC_W-1:0]  acc_q [LANES];
  logic [ACC_W-1:0]  acc_d [LANES];
  logic [DATA_W-1:0] opm_q [LANES];
  logic [DATA_W-1:0] rd_m  [LANES];
  logic [DATA_W-1:0] opv_q;

  logic [DATA_W-1:0] m_q [MAX_N][MAX_N];
  logic [DATA_W-1:0] v_q [MAX_N];

  int  drain_row;
  logic row_last;

  // Signed product sign-extended to ACC_W, added with optional clamp at the signed limits
  function automatic logic [ACC_W-1:0] mac(input logic [ACC_W-1:0] acc,
                                           input logic [DATA_W-1:0] a,
                                           input logic [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] p;
    logic [ACC_W:0] e;
    logic [ACC_W:0] s;
    p = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
    e = {{(ACC_W + 1 - 2*DATA_W){p[2*DATA_W-1]}}, p};
    s = {acc[ACC_W-1], acc} + e;
    if (SAT != 0 && s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  // Per-lane matrix read for column cyc_q; lanes past the store edge read zero
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      rd_m[l] = '0;
      if (int'(base_q) + l < MAX_N)
        rd_m[l] = m_q[IW'(int'(base_q) + l)][cyc_q[IW-1:0]];
    end
  end

  assign drain_row = int'(base_q) + int'(lane_q);
  assign row_last  = (drain_row == int'(n_q) - 1);

  // Next-state logic for the load / compute / drain sequencer
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    row_d   = row_q;
    col_d   = col_q;
    cyc_d   = cyc_q;
    base_d  = base_q;
    lane_d  = lane_q;
    err_d   = 1'b0;
    acc_d   = acc_q;
    case (state_q)
      S_IDLE: begin
        if (n_valid) begin
          if (n_in != '0 && n_in <= NW'(MAX_N)) begin
            n_d     = n_in;
            row_d   = '0;
            col_d   = '0;
            state_d = S_LOAD_M;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD_M: begin
        if (in_valid) begin
          if (col_q == n_q - NW'(1)) begin
            col_d = '0;
            if (row_q == n_q - NW'(1)) begin
              row_d   = '0;
              state_d = S_LOAD_V;
            end else begin
              row_d = row_q + NW'(1);
            end
          end else begin
            col_d = col_q + NW'(1);
          end
        end
      end
      S_LOAD_V: begin
        if (in_valid) begin
          if (col_q == n_q - NW'(1)) begin
            col_d   = '0;
            cyc_d   = '0;
            base_d  = '0;
            state_d = S_COMPUTE;
          end else begin
            col_d = col_q + NW'(1);
          end
        end
      end
      S_COMPUTE: begin
        // cycle 0 only fetches operands; cycles 1..N accumulate the previous fetch
        for (int l = 0; l < LANES; l++)
          acc_d[l] = (cyc_q == '0) ? '0 : mac(acc_q[l], opm_q[l], opv_q);
        if (cyc_q == n_q) begin
          lane_d  = '0;
          state_d = S_DRAIN;
        end else begin
          cyc_d = cyc_q + NW'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (row_last) begin
            state_d = S_IDLE;
          end else if (lane_q == LW'(LANES - 1)) begin
            base_d  = NW'(int'(base_q) + LANES);
            cyc_d   = '0;
            state_d = S_COMPUTE;
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control, accumulator and operand registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      cyc_q   <= '0;
      base_q  <= '0;
      lane_q  <= '0;
      err_q   <= 1'b0;
      opv_q   <= '0;
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= '0;
        opm_q[l] <= '0;
      end
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cyc_q   <= cyc_d;
      base_q  <= base_d;
      lane_q  <= lane_d;
      err_q   <= err_d;
      opv_q   <= v_q[cyc_q[IW-1:0]];
      for (int l = 0; l < LANES; l++) begin
        acc_q[l] <= acc_d[l];
        opm_q[l] <= rd_m[l];
      end
    end
  end

  // Matrix and vector stores; contents survive until overwritten by the next load
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD_M && in_valid)
      m_q[row_q[IW-1:0]][col_q[IW-1:0]] <= in_data;
    if (state_q == S_LOAD_V && in_valid)
      v_q[col_q[IW-1:0]] <= in_data;
  end

  assign in_ready  = (state_q == S_LOAD_M) || (state_q == S_LOAD_V);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DRAIN);
  assign out_data  = (state_q == S_DRAIN) ? acc_q[lane_q] : '0;
  assign out_last  = (state_q == S_DRAIN) && row_last;
  assign err       = err_q;

endmodule

// File: tb/tb_mxv_stream_engine.sv
// tb/tb_mxv_stream_engine.sv - directed self-checking bench for mxv_stream_engine
module tb_mxv_stream_engine;

  logic        clk;
  logic        reset;
  logic [3:0]  n_in;
  logic        n_valid;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        out_ready;

  logic        in_ready, out_valid, out_last, busy, err;
  logic [19:0] out_data;
  logic        s_in_ready, s_out_valid, s_out_last, s_busy, s_err;
  logic [15:0] s_out_data;
  logic        w_in_ready, w_out_valid, w_out_last, w_busy, w_err;
  logic [15:0] w_out_data;

  int checks   = 0;
  int failures = 0;

  int stim[$];
  int got_d[$];
  int got_l[$];
  int got_s[$];
  int got_w[$];
  int first_lat;
  int gap;

  mxv_stream_engine u_dut (
    .clk(clk), .reset(reset), .n_in(n_in), .n_valid(n_valid),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .err(err)
  );

  mxv_stream_engine #(.ACC_W(16), .SAT(1)) u_sat (
    .clk(clk), .reset(reset), .n_in(n_in), .n_valid(n_valid),
    .in_data(in_data), .in_valid(in_valid), .in_ready(s_in_ready),
    .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_last(s_out_last), .busy(s_busy), .err(s_err)
  );

  mxv_stream_engine #(.ACC_W(16), .SAT(0)) u_wrap (
    .clk(clk), .reset(reset), .n_in(n_in), .n_valid(n_valid),
    .in_data(in_data), .in_valid(in_valid), .in_ready(w_in_ready),
    .out_data(w_out_data), .out_valid(w_out_valid), .out_ready(out_ready),
    .out_last(w_out_last), .busy(w_busy), .err(w_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] m20(input int x);
    return 32'(x) & 32'h000F_FFFF;
  endfunction

  task automatic start(input int n);
    n_in    = 4'(n);
    n_valid = 1'b1;
    @(negedge clk);
    n_valid = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_in_ready", in_ready, 1);
  endtask

  task automatic load(input int n, input bit poke);
    for (int i = 0; i < n*n + n; i++) begin
      in_data  = 8'(stim[i]);
      in_valid = 1'b1;
      if (poke && i == 1) begin
        n_in    = 4'd1;
        n_valid = 1'b1;
      end
      @(negedge clk);
      if (poke && i == 1) begin
        n_valid = 1'b0;
        chk("nvalid_in_load_err", err, 0);
        chk("nvalid_in_load_busy", busy, 1);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic collect(input int nbeats, input bit rnd, input int budget);
    int waited = 0;
    int cnt = 0;
    bit stalled = 0;
    logic [19:0] hold_d = '0;
    logic hold_l = 1'b0;
    logic rdy;
    got_d.delete(); got_l.delete(); got_s.delete(); got_w.delete();
    first_lat = -1;
    gap = 0;
    while (cnt < nbeats && waited < budget) begin
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, hold_d);
        chk("stall_last", out_last, hold_l);
      end
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      if (out_valid) begin
        if (first_lat < 0) first_lat = waited;
        if (rdy) begin
          got_d.push_back(int'(out_data));
          got_l.push_back(int'(out_last));
          got_s.push_back(int'(s_out_data));
          got_w.push_back(int'(w_out_data));
          cnt++;
          stalled = 0;
        end else begin
          stalled = 1;
          hold_d  = out_data;
          hold_l  = out_last;
        end
      end else if (first_lat >= 0) begin
        gap++;
      end
      @(negedge clk);
      waited++;
    end
    out_ready = 1'b1;
    chk("beat_count", cnt, nbeats);
    chk("end_busy", busy, 0);
    chk("end_out_valid", out_valid, 0);
  endtask

  initial begin
    reset = 1'b1; n_in = '0; n_valid = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // N=2 basic, with a stray n_valid during the matrix load
    stim = '{1, 2, 3, 4, 5, 6};
    start(2);
    load(2, 1);
    collect(2, 0, 100);
    chk("n2_latency", first_lat, 3);
    if (got_d.size() == 2) begin
      chk("n2_row0", got_d[0], 17);
      chk("n2_row1", got_d[1], 39);
      chk("n2_last0", got_l[0], 0);
      chk("n2_last1", got_l[1], 1);
    end

    // Illegal N values
    n_in = 4'd0; n_valid = 1'b1;
    @(negedge clk);
    n_valid = 1'b0;
    chk("err_n0_pulse", err, 1);
    chk("err_n0_busy", busy, 0);
    chk("err_n0_in_ready", in_ready, 0);
    @(negedge clk);
    chk("err_n0_drop", err, 0);
    n_in = 4'd9; n_valid = 1'b1;
    @(negedge clk);
    n_valid = 1'b0;
    chk("err_n9_pulse", err, 1);
    chk("err_n9_busy", busy, 0);
    chk("err_n9_in_ready", in_ready, 0);
    @(negedge clk);
    chk("err_n9_drop", err, 0);
    chk("err_n9_busy_after", busy, 0);

    // N=5: two groups, masked lanes in the second
    stim.delete();
    for (int i = 0; i < 25; i++) stim.push_back(1);
    for (int i = 1; i <= 5; i++) stim.push_back(i);
    start(5);
    load(5, 0);
    collect(5, 0, 200);
    chk("n5_latency", first_lat, 6);
    chk("n5_second_compute", gap, 6);
    for (int i = 0; i < got_d.size(); i++) begin
      chk($sformatf("n5_row%0d", i), got_d[i], 15);
      chk($sformatf("n5_last%0d", i), got_l[i], (i == 4) ? 1 : 0);
    end

    // N=4 signed vectors with random backpressure
    stim = '{3, -2, 7, 0,  -5, 4, 1, -1,  127, -128, 2, 3,  -7, -7, -7, -7,  2, -3, 5, 10};
    start(4);
    load(4, 0);
    collect(4, 1, 400);
    if (got_d.size() == 4) begin
      chk("n4_row0", got_d[0], m20(47));
      chk("n4_row1", got_d[1], m20(-27));
      chk("n4_row2", got_d[2], m20(678));
      chk("n4_row3", got_d[3], m20(-98));
      chk("n4_last3", got_l[3], 1);
    end

    // N=8 all -128: saturating vs wrapping 16-bit accumulators
    stim.delete();
    for (int i = 0; i < 72; i++) stim.push_back(-128);
    start(8);
    load(8, 0);
    collect(8, 0, 300);
    for (int i = 0; i < got_d.size(); i++) begin
      chk($sformatf("n8_acc20_row%0d", i), got_d[i], 131072);
      chk($sformatf("n8_sat_row%0d", i), got_s[i], 32767);
      chk($sformatf("n8_wrap_row%0d", i), got_w[i], 0);
    end

    // Reset in the middle of a matrix load, then a fresh run
    stim = '{9, 9, 9};
    start(2);
    for (int i = 0; i < 3; i++) begin
      in_data = 8'(stim[i]); in_valid = 1'b1;
      @(negedge clk);
    end
    #2;
    reset = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_in_ready", in_ready, 0);
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_err", err, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    stim = '{1, 2, 3, 4, 5, 6};
    start(2);
    load(2, 0);
    collect(2, 0, 100);
    if (got_d.size() == 2) begin
      chk("rerun_row0", got_d[0], 17);
      chk("rerun_row1", got_d[1], 39);
      chk("rerun_last1", got_l[1], 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
